// File: rtl/cache_arbiter_control.sv
// cache_arbiter_control
// Arbitrates L2 access between the I-cache line-fill path and the D-cache
// fill/writeback path. One transaction is in flight at a time:
//   IDLE -> (I_RD | D_RD | D_WR) -> DONE -> IDLE
// Grant-cycle controls (load_mar, cache_address_sel, load_mdr_l1_to_l2) are
// produced combinationally in IDLE so the MAR captures the winner's address
// on the same edge that moves the FSM into its busy state.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   undefined : dcache always wins when both caches request.
//   defined   : a 1-bit last_grant register alternates the winner under
//               contention (dcache wins the first contention after reset).

module cache_arbiter_control (
  input  logic       clk,
  input  logic       rst,
  input  logic       icache_read,
  input  logic       dcache_read,
  input  logic       dcache_write,
  input  logic       l2_resp,
  output logic       cache_address_sel,
  output logic [1:0] cache_read_sel,
  output logic       cache_write_sel,
  output logic       cache_resp_sel,
  output logic       load_mar,
  output logic       load_mdr_l1_to_l2,
  output logic       load_mdr_l2_to_l1,
  output logic       l2_read,
  output logic       l2_write
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    I_RD = 3'd1,
    D_RD = 3'd2,
    D_WR = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [1:0] RSEL_NONE   = 2'b00;
  localparam logic [1:0] RSEL_ICACHE = 2'b01;
  localparam logic [1:0] RSEL_DCACHE = 2'b10;

  state_t state_q, state_d;

  // Remembers which cache owned the last transaction so DONE can keep the
  // response steering stable while the datapath's registered response lands.
  logic resp_sel_q, resp_sel_d;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = dcache received the most recent grant, 0 = icache.
  logic last_grant_q, last_grant_d;
`endif

  logic dcache_req;
  logic any_req;
  logic grant_dcache;
  logic grant_write;

  // Pick the winner among the current requests; a dcache writeback beats a
  // dcache fill so dirty data leaves before the line is refilled.
  always_comb begin
    dcache_req = dcache_read | dcache_write;
    any_req    = icache_read | dcache_req;
`ifdef ARB_ROUND_ROBIN_EN
    if (icache_read && dcache_req) begin
      grant_dcache = ~last_grant_q;
    end else begin
      grant_dcache = dcache_req;
    end
`else
    grant_dcache = dcache_req;
`endif
    grant_write = grant_dcache & dcache_write;
  end

  // Next-state and output decode; reset overrides everything so an aborted
  // transaction never pulses a load or an L2 strobe.
  always_comb begin
    state_d           = state_q;
    resp_sel_d        = resp_sel_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d      = last_grant_q;
`endif
    cache_address_sel = 1'b0;
    cache_read_sel    = RSEL_NONE;
    cache_write_sel   = 1'b0;
    cache_resp_sel    = 1'b0;
    load_mar          = 1'b0;
    load_mdr_l1_to_l2 = 1'b0;
    load_mdr_l2_to_l1 = 1'b0;
    l2_read           = 1'b0;
    l2_write          = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          load_mar          = 1'b1;
          cache_address_sel = grant_dcache;
          load_mdr_l1_to_l2 = grant_write;
          resp_sel_d        = grant_dcache;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d      = grant_dcache;
`endif
          if (grant_write) begin
            state_d = D_WR;
          end else if (grant_dcache) begin
            state_d = D_RD;
          end else begin
            state_d = I_RD;
          end
        end
      end

      I_RD: begin
        l2_read        = 1'b1;
        cache_read_sel = RSEL_ICACHE;
        cache_resp_sel = 1'b0;
        if (l2_resp) begin
          load_mdr_l2_to_l1 = 1'b1;
          state_d           = DONE;
        end
      end

      D_RD: begin
        l2_read        = 1'b1;
        cache_read_sel = RSEL_DCACHE;
        cache_resp_sel = 1'b1;
        if (l2_resp) begin
          load_mdr_l2_to_l1 = 1'b1;
          state_d           = DONE;
        end
      end

      D_WR: begin
        l2_write        = 1'b1;
        cache_write_sel = 1'b1;
        cache_resp_sel  = 1'b1;
        if (l2_resp) begin
          state_d = DONE;
        end
      end

      DONE: begin
        cache_resp_sel = resp_sel_q;
        state_d        = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (rst) begin
      cache_address_sel = 1'b0;
      cache_read_sel    = RSEL_NONE;
      cache_write_sel   = 1'b0;
      cache_resp_sel    = 1'b0;
      load_mar          = 1'b0;
      load_mdr_l1_to_l2 = 1'b0;
      load_mdr_l2_to_l1 = 1'b0;
      l2_read           = 1'b0;
      l2_write          = 1'b0;
    end
  end

  // State registers with synchronous reset back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      resp_sel_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      resp_sel_q   <= resp_sel_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

`ifndef SYNTHESIS
  // Never drive both L2 strobes, and never drive either outside a busy state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(l2_read && l2_write))
        else $error("l2_read and l2_write both high");
      assert (!((l2_read || l2_write) && (state_q == IDLE || state_q == DONE)))
        else $error("L2 strobe outside a busy state");
    end
  end
`endif

endmodule

// File: tb/tb_cache_arbiter_control.sv
// Testbench for cache_arbiter_control.
// Directed vector table, hand-written multi-cycle sequences, then random
// traffic compared against a transaction-level reference model.
// Build with +define+ARB_ROUND_ROBIN_EN to check the round-robin variant.

module tb_cache_arbiter_control;

  logic       clk;
  logic       rst;
  logic       icache_read;
  logic       dcache_read;
  logic       dcache_write;
  logic       l2_resp;
  logic       cache_address_sel;
  logic [1:0] cache_read_sel;
  logic       cache_write_sel;
  logic       cache_resp_sel;
  logic       load_mar;
  logic       load_mdr_l1_to_l2;
  logic       load_mdr_l2_to_l1;
  logic       l2_read;
  logic       l2_write;

  int nChecks = 0;
  int nFails  = 0;

  cache_arbiter_control dut (
    .clk               (clk),
    .rst               (rst),
    .icache_read       (icache_read),
    .dcache_read       (dcache_read),
    .dcache_write      (dcache_write),
    .l2_resp           (l2_resp),
    .cache_address_sel (cache_address_sel),
    .cache_read_sel    (cache_read_sel),
    .cache_write_sel   (cache_write_sel),
    .cache_resp_sel    (cache_resp_sel),
    .load_mar          (load_mar),
    .load_mdr_l1_to_l2 (load_mdr_l1_to_l2),
    .load_mdr_l2_to_l1 (load_mdr_l2_to_l1),
    .l2_read           (l2_read),
    .l2_write          (l2_write)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges the stimulus
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Output bundle order: {addr_sel, read_sel[1:0], write_sel, resp_sel,
  //                       load_mar, l1_to_l2, l2_to_l1, l2_read, l2_write}
  logic [9:0] actual;
  assign actual = {cache_address_sel, cache_read_sel, cache_write_sel,
                   cache_resp_sel, load_mar, load_mdr_l1_to_l2,
                   load_mdr_l2_to_l1, l2_read, l2_write};

  function automatic logic [9:0] o(input logic as, input logic [1:0] rs,
                                   input logic ws, input logic rsp,
                                   input logic mar, input logic l12,
                                   input logic l21, input logic rd,
                                   input logic wr);
    return {as, rs, ws, rsp, mar, l12, l21, rd, wr};
  endfunction

  typedef struct {
    logic       r;
    logic       ir;
    logic       dr;
    logic       dw;
    logic       rp;
    logic [9:0] exp;
  } vec_t;

  // Drive inputs just after the falling edge, well away from the rising edge
  task automatic applyStimulus(input logic r, input logic ir, input logic dr,
                               input logic dw, input logic rp);
    @(negedge clk);
    rst          = r;
    icache_read  = ir;
    dcache_read  = dr;
    dcache_write = dw;
    l2_resp      = rp;
    #1;
  endtask

  task automatic checkOutput(input logic [9:0] exp, input string tag);
    nChecks++;
    if (actual !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %b want %b (as,rs2,ws,rsp,mar,l12,l21,rd,wr)",
               tag, actual, exp);
    end
  endtask

  task automatic step(input logic r, input logic ir, input logic dr,
                      input logic dw, input logic rp, input logic [9:0] exp,
                      input string tag);
    applyStimulus(r, ir, dr, dw, rp);
    checkOutput(exp, tag);
  endtask

  // ---------------- transaction-level reference model ----------------
  // mPhase: 0 = waiting for a request, 1 = transaction with L2 outstanding,
  //         2 = one settle cycle after L2 finished.
  int mPhase;
  bit mOwnerD;
  bit mIsWrite;
  bit mLastD;

  task automatic modelReset();
    mPhase   = 0;
    mOwnerD  = 0;
    mIsWrite = 0;
    mLastD   = 0;
  endtask

  // Returns the outputs expected for this cycle and advances the model past
  // the following clock edge; finished reports a transaction that just
  // completed and which side it belonged to.
  task automatic modelStep(input logic r, input logic ir, input logic dr,
                           input logic dw, input logic rp,
                           output logic [9:0] e, output bit finished,
                           output bit finishedD);
    bit pickD;
    e         = '0;
    finished  = 0;
    finishedD = 0;
    if (r) begin
      modelReset();
      return;
    end
    if (mPhase == 0) begin
      if (ir || dr || dw) begin
        if ((dr || dw) && ir) begin
`ifdef ARB_ROUND_ROBIN_EN
          pickD = !mLastD;
`else
          pickD = 1;
`endif
        end else begin
          pickD = dr || dw;
        end
        mOwnerD  = pickD;
        mIsWrite = pickD && dw;
        mLastD   = pickD;
        e = o(pickD, 2'd0, 0, 0, 1, mIsWrite, 0, 0, 0);
        mPhase = 1;
      end
    end else if (mPhase == 1) begin
      if (mIsWrite) begin
        e = o(0, 2'd0, 1, 1, 0, 0, 0, 0, 1);
      end else begin
        e = o(0, mOwnerD ? 2'd2 : 2'd1, 0, mOwnerD, 0, 0, rp, 1, 0);
      end
      if (rp) begin
        mPhase    = 2;
        finished  = 1;
        finishedD = mOwnerD;
      end
    end else begin
      e = o(0, 2'd0, 0, mOwnerD, 0, 0, 0, 0, 0);
      mPhase = 0;
    end
  endtask

  // --------------------------- main test ---------------------------
  initial begin
    vec_t vecs[20];
    logic [9:0] z;
    bit grants[$];
    bit expGrants[4];
    int age;
    logic rp;
    bit pendI, pendD;
    int dKind;
    logic [9:0] e;
    bit fin, finD;
    logic r, ir, dr, dw;

    z = '0;
    rst = 1'b1; icache_read = 0; dcache_read = 0; dcache_write = 0; l2_resp = 0;

    // Directed vector table (starts from power-on with reset asserted)
    vecs[0]  = '{1, 0, 0, 0, 0, z};
    vecs[1]  = '{1, 0, 0, 0, 0, z};
    vecs[2]  = '{0, 0, 0, 0, 0, z};
    vecs[3]  = '{0, 1, 0, 0, 0, o(0, 2'd0, 0, 0, 1, 0, 0, 0, 0)};
    vecs[4]  = '{0, 1, 0, 0, 0, o(0, 2'd1, 0, 0, 0, 0, 0, 1, 0)};
    vecs[5]  = '{0, 1, 0, 0, 0, o(0, 2'd1, 0, 0, 0, 0, 0, 1, 0)};
    vecs[6]  = '{0, 1, 0, 0, 1, o(0, 2'd1, 0, 0, 0, 0, 1, 1, 0)};
    vecs[7]  = '{0, 0, 0, 0, 0, z};
    vecs[8]  = '{0, 0, 1, 1, 0, o(1, 2'd0, 0, 0, 1, 1, 0, 0, 0)};
    vecs[9]  = '{0, 0, 1, 1, 0, o(0, 2'd0, 1, 1, 0, 0, 0, 0, 1)};
    vecs[10] = '{0, 0, 1, 1, 1, o(0, 2'd0, 1, 1, 0, 0, 0, 0, 1)};
    vecs[11] = '{0, 0, 1, 0, 1, o(0, 2'd0, 0, 1, 0, 0, 0, 0, 0)};
    vecs[12] = '{0, 0, 1, 0, 0, o(1, 2'd0, 0, 0, 1, 0, 0, 0, 0)};
    vecs[13] = '{0, 1, 1, 0, 0, o(0, 2'd2, 0, 1, 0, 0, 0, 1, 0)};
    vecs[14] = '{0, 1, 1, 0, 1, o(0, 2'd2, 0, 1, 0, 0, 1, 1, 0)};
    vecs[15] = '{0, 1, 0, 0, 0, o(0, 2'd0, 0, 1, 0, 0, 0, 0, 0)};
    vecs[16] = '{0, 1, 0, 0, 0, o(0, 2'd0, 0, 0, 1, 0, 0, 0, 0)};
    vecs[17] = '{1, 1, 0, 0, 0, z};
    vecs[18] = '{0, 0, 0, 0, 1, z};
    vecs[19] = '{0, 0, 0, 0, 0, z};

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].r, vecs[i].ir, vecs[i].dr, vecs[i].dw, vecs[i].rp,
           vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Reset for two cycles then ten quiet cycles
    step(1, 0, 0, 0, 0, z, "rst_a");
    step(1, 0, 0, 0, 0, z, "rst_b");
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 0, z, $sformatf("idle%0d", i));
    end

    // Reset during D_RD with a simultaneous l2_resp aborts cleanly
    step(0, 0, 1, 0, 0, o(1, 2'd0, 0, 0, 1, 0, 0, 0, 0), "abort_grant");
    step(0, 0, 1, 0, 0, o(0, 2'd2, 0, 1, 0, 0, 0, 1, 0), "abort_drd");
    step(1, 0, 1, 0, 1, z, "abort_rst");
    step(0, 0, 0, 0, 0, z, "abort_after");
    step(0, 1, 0, 0, 0, o(0, 2'd0, 0, 0, 1, 0, 0, 0, 0), "abort_regrant");
    step(0, 0, 0, 0, 1, o(0, 2'd1, 0, 0, 0, 0, 1, 1, 0), "abort_irdresp");
    step(0, 0, 0, 0, 0, z, "abort_done");

    // Contention: both caches hold requests, L2 answers two cycles in
    step(1, 0, 0, 0, 0, z, "cont_rst");
`ifdef ARB_ROUND_ROBIN_EN
    expGrants = '{1, 0, 1, 0};
`else
    expGrants = '{1, 1, 1, 1};
`endif
    age = -1;
    for (int c = 0; c < 60 && grants.size() < 4; c++) begin
      if (age >= 0) age++;
      rp = (age == 2);
      applyStimulus(0, 1, 1, 0, rp);
      if (rp) age = -1;
      if (load_mar) begin
        grants.push_back(cache_address_sel);
        age = 0;
      end
    end
    nChecks++;
    if (grants.size() != 4) begin
      nFails++;
      $display("[TB] FAIL cont_count: got %0d grants want 4", grants.size());
    end else begin
      for (int g = 0; g < 4; g++) begin
        nChecks++;
        if (grants[g] != expGrants[g]) begin
          nFails++;
          $display("[TB] FAIL cont_grant%0d: got %0d want %0d (1=dcache)",
                   g, grants[g], expGrants[g]);
        end
      end
    end

    // Random traffic against the reference model
    step(1, 0, 0, 0, 0, z, "rand_rst");
    modelReset();
    pendI = 0; pendD = 0; dKind = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!pendI && ($urandom % 4 == 0)) pendI = 1;
      if (!pendD && ($urandom % 4 == 0)) begin
        pendD = 1;
        dKind = int'($urandom % 3);
      end
      r  = ($urandom % 64 == 0);
      ir = pendI;
      dr = pendD && (dKind != 1);
      dw = pendD && (dKind != 0);
      rp = ($urandom % 3 == 0);
      applyStimulus(r, ir, dr, dw, rp);
      modelStep(r, ir, dr, dw, rp, e, fin, finD);
      checkOutput(e, $sformatf("rand%0d", c));
      if (fin) begin
        if (finD) pendD = 0;
        else      pendI = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
